aes_iter_cipher_ctrl: RTL and testbench

- Iterative AES block-cipher sequencer.
- Accepts one data block and one pre-expanded key schedule per transaction over a valid/ready handshake.
- Drives a shared external round unit once per cycle and returns the result over an output valid/ready handshake with backpressure.
- Parametrised successor of the fixed 128-bit encrypt-only round loop:
  - per-transaction key size (128/192/256);
  - encrypt/decrypt direction;
  - explicit reset;
  - flow control.

---
 rtl/aes_iter_cipher_ctrl.sv | 119 +++++++++++
 tb/tb_aes_iter_cipher_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_cipher_ctrl.sv
// Iterative AES round sequencer: latches a block, walks the expanded key schedule
// through an external combinational round unit, and hands back the result with backpressure.
module aes_iter_cipher_ctrl #(
   parameter int DATA_W = 128,
   parameter int MAX_NR = 14,
   parameter int KEY_W  = DATA_W * (MAX_NR + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [KEY_W-1:0]  key_exp,
   input  logic [1:0]        key_size,
   input  logic              dec,
   output logic [DATA_W-1:0] round_state,
   output logic [DATA_W-1:0] round_key,
   output logic              round_last,
   output logic              round_dec,
   input  logic [DATA_W-1:0] round_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic [3:0]        round_cnt
);

   // Handshakes: a transfer happens on the rising edge where valid && ready;
   // valid never waits on ready, and out_data holds while out_valid && !out_ready.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_fsm;
   state_t            w_fsm_nxt;
   logic [DATA_W-1:0] r_state;
   logic [DATA_W-1:0] r_out_data;
   logic [3:0]        r_cnt;
   logic [3:0]        r_nr;
   logic              r_dec;

   logic [DATA_W-1:0] w_rk [0:MAX_NR];
   logic [3:0]        w_new_nr;
   logic [3:0]        w_k0;
   logic [3:0]        w_run_idx;
   logic              w_accept;
   logic              w_last;

   for (genvar gi = 0; gi <= MAX_NR; gi++) begin : g_rk
      assign w_rk[gi] = key_exp[gi*DATA_W +: DATA_W];
   end

   always_comb begin
      w_new_nr = 4'd14;
      case (key_size)
         2'b00:   w_new_nr = 4'd10;
         2'b01:   w_new_nr = 4'd12;
         default: w_new_nr = 4'd14;
      endcase
   end

   // Decrypt walks the schedule backwards; the initial whitening uses rk[Nr].
   assign w_k0      = dec ? w_new_nr : 4'd0;
   assign w_run_idx = r_dec ? (r_nr - r_cnt) : r_cnt;
   assign w_last    = (r_cnt == r_nr);

   assign in_ready    = (r_fsm == S_IDLE) || ((r_fsm == S_DONE) && out_ready);
   assign w_accept    = in_valid && in_ready;
   assign out_valid   = (r_fsm == S_DONE);
   assign busy        = (r_fsm != S_IDLE);
   assign out_data    = r_out_data;
   assign round_cnt   = r_cnt;
   assign round_state = r_state;
   assign round_key   = w_rk[w_run_idx];
   assign round_last  = (r_fsm == S_RUN) && w_last;
   assign round_dec   = r_dec;

   always_comb begin
      w_fsm_nxt = r_fsm;
      case (r_fsm)
         S_IDLE: if (w_accept) w_fsm_nxt = S_RUN;
         S_RUN:  if (w_last) w_fsm_nxt = S_DONE;
         S_DONE: begin
            if (w_accept)       w_fsm_nxt = S_RUN;
            else if (out_ready) w_fsm_nxt = S_IDLE;
         end
         default: w_fsm_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_fsm <= S_IDLE;
      else     r_fsm <= w_fsm_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= '0;
         r_out_data <= '0;
         r_cnt      <= 4'd0;
         r_nr       <= 4'd10;
         r_dec      <= 1'b0;
      end else if (w_accept) begin
         r_nr    <= w_new_nr;
         r_dec   <= dec;
         r_state <= in_data ^ w_rk[w_k0];
         r_cnt   <= 4'd1;
      end else if (r_fsm == S_RUN) begin
         r_state <= round_result;
         if (w_last) r_out_data <= round_result;
         else        r_cnt      <= r_cnt + 4'd1;
      end else if ((r_fsm == S_DONE) && out_ready) begin
         r_cnt <= 4'd0;
      end
   end

endmodule

// File: tb/tb_aes_iter_cipher_ctrl.sv
// Bench for aes_iter_cipher_ctrl: XOR round-unit stub, rk[i] = i, directed vectors
// with hand-computed results checked through a scoreboard queue.
module tb_aes_iter_cipher_ctrl;

   localparam int DATA_W = 128;
   localparam int MAX_NR = 14;
   localparam int KEY_W  = DATA_W * (MAX_NR + 1);

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [KEY_W-1:0]  key_exp;
   logic [1:0]        key_size;
   logic              dec;
   logic [DATA_W-1:0] round_state;
   logic [DATA_W-1:0] round_key;
   logic              round_last;
   logic              round_dec;
   logic [DATA_W-1:0] round_result;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              busy;
   logic [3:0]        round_cnt;

   aes_iter_cipher_ctrl #(.DATA_W(DATA_W), .MAX_NR(MAX_NR)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .key_exp(key_exp), .key_size(key_size), .dec(dec),
      .round_state(round_state), .round_key(round_key),
      .round_last(round_last), .round_dec(round_dec),
      .round_result(round_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .round_cnt(round_cnt)
   );

   assign round_result = round_state ^ round_key;

   // clock / reset / cycle count
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard state
   logic [DATA_W-1:0] exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cur_acc  = 0;
   int   cur_nr   = 0;
   logic cur_dec  = 1'b0;
   logic cur_active = 1'b0;
   logic prev_ov  = 1'b0;
   int   mon_r;

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // monitor: per-round checks, latency, and result consumption
   always @(negedge clk) begin
      if (!rst) begin
         if (cur_active) begin
            mon_r = cyc - cur_acc + 1;
            if (mon_r >= 1 && mon_r <= cur_nr) begin
               chk("round_key", round_key, DATA_W'(cur_dec ? (cur_nr - mon_r) : mon_r));
               chk("round_last", DATA_W'(round_last), DATA_W'(mon_r == cur_nr));
               chk("round_dec", DATA_W'(round_dec), DATA_W'(cur_dec));
               chk("round_cnt", DATA_W'(round_cnt), DATA_W'(mon_r));
               chk("busy_run", DATA_W'(busy), DATA_W'(1));
               chk("out_valid_run", DATA_W'(out_valid), DATA_W'(0));
            end
         end
         if (out_valid && !prev_ov) begin
            if (!cur_active) fail_now("unexpected_out_valid");
            else chk("latency", DATA_W'(cyc), DATA_W'(cur_acc + cur_nr));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) fail_now("unexpected_output");
            else chk("out_data", out_data, exp_q.pop_front());
         end
      end
      prev_ov = out_valid;
   end

   // driver: offer a block, wait for acceptance, then scramble sideband inputs
   task automatic send(input logic [DATA_W-1:0] d, input logic [1:0] ks, input logic dc,
                       input logic [DATA_W-1:0] exp, input int nr);
      bit ok;
      ok       = 1'b0;
      in_data  = d;
      key_size = ks;
      dec      = dc;
      in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         fail_now("accept_timeout");
      end else begin
         @(posedge clk);
         #1;
         cur_acc    = cyc;
         cur_nr     = nr;
         cur_dec    = dc;
         cur_active = 1'b1;
         exp_q.push_back(exp);
      end
      in_valid = 1'b0;
      key_size = ~ks;
      dec      = ~dc;
      in_data  = '1;
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_now("drain_timeout");
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit ok;
      for (int i = 0; i <= MAX_NR; i++) key_exp[i*DATA_W +: DATA_W] = DATA_W'(i);
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      key_size  = 2'b00;
      dec       = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_in_ready", DATA_W'(in_ready), DATA_W'(1));
      chk("reset_busy", DATA_W'(busy), DATA_W'(0));
      chk("reset_out_valid", DATA_W'(out_valid), DATA_W'(0));
      chk("reset_round_cnt", DATA_W'(round_cnt), DATA_W'(0));
      chk("reset_out_data", out_data, DATA_W'(0));
      chk("reset_round_last", DATA_W'(round_last), DATA_W'(0));
      @(posedge clk);
      #1;

      // encrypt, each key size
      send(128'hFF, 2'b00, 1'b0, 128'hF4, 10); drain();
      send(128'h00, 2'b01, 1'b0, 128'h0C, 12); drain();
      send(128'h00, 2'b10, 1'b0, 128'h0F, 14); drain();
      send(128'h00, 2'b11, 1'b0, 128'h0F, 14); drain();

      // decrypt
      send(128'h1234, 2'b00, 1'b1, 128'h123F, 10); drain();
      send(128'hDEAD_BEEF_0000_0000_0000_0000_0000_00F0, 2'b00, 1'b1,
           128'hDEAD_BEEF_0000_0000_0000_0000_0000_00FB, 10);
      drain();

      // backpressure then back-to-back acceptance
      out_ready = 1'b0;
      send(128'hA5, 2'b00, 1'b0, 128'hAE, 10);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_now("bp_valid_timeout");
      @(posedge clk);
      #1;
      in_data  = 128'h55;
      key_size = 2'b01;
      dec      = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_data", out_data, 128'hAE);
         chk("bp_in_ready", DATA_W'(in_ready), DATA_W'(0));
         chk("bp_out_valid", DATA_W'(out_valid), DATA_W'(1));
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(128'h55, 2'b01, 1'b1, 128'h59, 12);
      drain();

      // asynchronous reset in the middle of a transaction
      send(128'h77, 2'b10, 1'b0, 128'h78, 14);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (round_cnt == 4'd5) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_now("round5_timeout");
      #2 rst = 1'b1;
      cur_active = 1'b0;
      exp_q.delete();
      #1;
      chk("async_busy", DATA_W'(busy), DATA_W'(0));
      chk("async_out_valid", DATA_W'(out_valid), DATA_W'(0));
      chk("async_round_cnt", DATA_W'(round_cnt), DATA_W'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_reset_in_ready", DATA_W'(in_ready), DATA_W'(1));
      chk("post_reset_out_data", out_data, DATA_W'(0));
      @(posedge clk);
      #1;
      send(128'h3C, 2'b00, 1'b0, 128'h37, 10);
      drain();
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout (cycle %0d)", cyc);
      $fatal(1, "global timeout");
   end

endmodule
